register_file: RTL and testbench
================================

Name: register_file

Overview:
- General-purpose register file for the 8-bit core datapath: 8 data registers plus one separate flag register.
- One synchronous write port and two independent asynchronous read ports with output enables.
- Flag register has its own load path and always-visible output; sits between the ALU/bus and the control unit.

Parameters:
- DATASIZE, 8, width of every data register and the flag register (multiple of 4).
- REGBIT, 3, register address width; register count RCOUNT = 2**REGBIT = 8 (fixed, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wrenb  input  1  write enable for the data registers.
- flenb  input  1  flag register load enable.
- r1enb  input  1  read port 1 output enable.
- r2enb  input  1  read port 2 output enable.
- waddr  input  REGBIT  write address.
- r1add  input  REGBIT  read port 1 address.
- r2add  input  REGBIT  read port 2 address.
- wdata  input  DATASIZE  write data.
- ifdat  input  DATASIZE  flag input data.
- r1dat  output  DATASIZE  read port 1 data.
- r2dat  output  DATASIZE  read port 2 data.
- ofdat  output  DATASIZE  flag register contents.

Behaviour:
- Reset: rst low asynchronously clears all 8 data registers and the flag register to 0, regardless of clk. While rst is low, writes are ignored. ofdat = 0; r1dat/r2dat = 0.
- Write: on rising clk with rst high and wrenb=1, register[waddr] <= wdata. Only the addressed register changes. One-cycle latency: the new value is visible after the edge.
- Flag: on rising clk with rst high and flenb=1, flag <= ifdat. Flag is independent of wrenb/waddr. Simultaneous wrenb and flenb both take effect.
- Read: combinational. r1dat = register[r1add] when r1enb=1, else all zeros. r2dat is the same using r2add/r2enb. Both ports may address the same register.
- ofdat: combinational copy of the flag register; always driven, with no enable.
- Read/write same address in the same cycle: the read returns the old value until the clock edge (no bypass, unless the optional feature is enabled).
- All addresses 0..7 are valid; there is no out-of-range case.
- Reset asserted mid-operation: any pending write is dropped; registers read 0 on the next cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wrenb=1 and a read port's address equals waddr with that port enabled, the port returns wdata combinationally (write-through forwarding).
- Not defined: reads always return stored register contents (old value before the write edge).

Decomposition:
- Shared package holds:
  - DATASIZE default (8), REGBIT (3), RCOUNT (8) constants;
  - a data-word typedef and a register-address typedef.
- Natural sub-module: regfile_cell, a DATASIZE-bit register with async active-low clear, load enable, data_in and data_out.
  - Instantiate 8 cells in a generate block named reg_block, instance name regs.
  - Use one more cell for the flag register.

Test Plan:
- Reset: hold rst low 5 cycles → all registers and ofdat = 00; r1dat/r2dat = 00 with enables high.
- Write reg0: waddr=0, wdata=AA, wrenb pulse 1 cycle, r1add=0, r1enb=1 → r1dat=AA after the edge; regs 1–7 stay 00. Then write 55 → r1dat=55.
- Write reg1: AA then 55 via the same sequence → r1dat matches each value; reg0 keeps 55.
- Flag: ifdat=AA, flenb pulse → ofdat=AA; then ifdat=55 → ofdat=55; data registers unchanged.
- Dual read: reg0=55, reg1=AA, r1add=0, r2add=1, both enables high → r1dat=55, r2dat=AA; drop r2enb → r2dat=00.
- Same-cycle read/write: reg2=11, write 22 to reg2 while reading it → 11 before the edge (22 with REGFILE_BYPASS_EN), 22 after; assert rst mid-write → reg2=00.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants and types for the 8-entry register file plus flag register.
package register_file_pkg;

    localparam int DEF_DATASIZE = 8;
    localparam int REGBIT       = 3;
    localparam int RCOUNT       = 2 ** REGBIT;

    typedef logic [DEF_DATASIZE-1:0] data_t;
    typedef logic [REGBIT-1:0]       addr_t;

endpackage

// File: rtl/regfile_cell.sv
// One register with asynchronous active-low clear and a synchronous load enable.
module regfile_cell
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_DATASIZE
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/register_file.sv
// 8 x DATASIZE register file: one synchronous write port, two gated async read ports, separate flag register.
// Define REGFILE_BYPASS_EN to forward write data to a read port addressing the register being written.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrenb,
    input  logic                flenb,
    input  logic                r1enb,
    input  logic                r2enb,
    input  addr_t               waddr,
    input  addr_t               r1add,
    input  addr_t               r2add,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [DATASIZE-1:0] ifdat,
    output logic [DATASIZE-1:0] r1dat,
    output logic [DATASIZE-1:0] r2dat,
    output logic [DATASIZE-1:0] ofdat
);

    logic [DATASIZE-1:0] reg_q [RCOUNT];

    generate
        for (genvar gi = 0; gi < RCOUNT; gi++) begin : reg_block
            logic load;
            assign load = wrenb && (waddr == addr_t'(gi));

            regfile_cell #(.WIDTH(DATASIZE)) regs (
                .clk      (clk),
                .clr_n    (rst),
                .load     (load),
                .data_in  (wdata),
                .data_out (reg_q[gi])
            );
        end
    endgenerate

    regfile_cell #(.WIDTH(DATASIZE)) flag_cell (
        .clk      (clk),
        .clr_n    (rst),
        .load     (flenb),
        .data_in  (ifdat),
        .data_out (ofdat)
    );

    always_comb begin
        r1dat = '0;
        r2dat = '0;
        if (r1enb) begin
            r1dat = reg_q[r1add];
        end
        if (r2enb) begin
            r2dat = reg_q[r2add];
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by rst so held-reset reads stay zero.
        if (rst && wrenb && r1enb && (r1add == waddr)) begin
            r1dat = wdata;
        end
        if (rst && wrenb && r2enb && (r2add == waddr)) begin
            r2dat = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed self-checking bench for register_file against an array-based model.
module tb_register_file;
    import register_file_pkg::*;

    logic  clk = 1'b0;
    logic  rst, wrenb, flenb, r1enb, r2enb;
    addr_t waddr, r1add, r2add;
    data_t wdata, ifdat, r1dat, r2dat, ofdat;

    int    n_tests = 0;
    int    n_fail  = 0;
    data_t mem [RCOUNT];
    data_t flag;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    register_file dut (
        .clk   (clk),
        .rst   (rst),
        .wrenb (wrenb),
        .flenb (flenb),
        .r1enb (r1enb),
        .r2enb (r2enb),
        .waddr (waddr),
        .r1add (r1add),
        .r2add (r2add),
        .wdata (wdata),
        .ifdat (ifdat),
        .r1dat (r1dat),
        .r2dat (r2dat),
        .ofdat (ofdat)
    );

    task automatic check(input string tag, input data_t obs, input data_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic data_t model_read(input bit en, input addr_t a);
        if (!rst || !en) return '0;
        if (BYPASS && wrenb && (a == waddr)) return wdata;
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RCOUNT; i++) mem[i] = '0;
        flag = '0;
    endtask

    // One transaction: drive at negedge, check combinational outputs, commit at posedge.
    task automatic cycle(input string tag, input bit we, input addr_t wa, input data_t wd,
                         input bit fe, input data_t fd,
                         input bit e1, input addr_t a1, input bit e2, input addr_t a2);
        wrenb = we; waddr = wa; wdata = wd;
        flenb = fe; ifdat = fd;
        r1enb = e1; r1add = a1; r2enb = e2; r2add = a2;
        #1;
        check({tag, "/r1"}, r1dat, model_read(e1, a1));
        check({tag, "/r2"}, r2dat, model_read(e2, a2));
        check({tag, "/of"}, ofdat, rst ? flag : '0);
        $display("[TB] %s rst=%0b we=%0b wa=%0d wd=%02h fe=%0b fd=%02h r1[%0d]=%02h r2[%0d]=%02h of=%02h",
                 tag, rst, we, wa, wd, fe, fd, a1, r1dat, a2, r2dat, ofdat);
        @(posedge clk);
        if (rst) begin
            if (we) mem[wa] = wd;
            if (fe) flag = fd;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wrenb = 0; flenb = 0; r1enb = 0; r2enb = 0;
        waddr = '0; r1add = '0; r2add = '0; wdata = '0; ifdat = '0;
        model_clear();
        #2 rst = 1'b0;
        @(negedge clk);

        // Reset held: writes ignored, all reads zero.
        for (int i = 0; i < 5; i++)
            cycle("reset", 1'b1, addr_t'(i), 8'hFF, 1'b1, 8'hFF, 1'b1, addr_t'(i), 1'b1, addr_t'(7 - i));
        rst = 1'b1;
        for (int i = 0; i < RCOUNT; i++)
            cycle("post_rst", 1'b0, '0, '0, 1'b0, '0, 1'b1, addr_t'(i), 1'b1, addr_t'(i));

        // Directed writes to reg0 and reg1.
        cycle("wr0_aa", 1'b1, 3'd0, 8'hAA, 1'b0, '0, 1'b1, 3'd0, 1'b0, '0);
        cycle("rd0_aa", 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd0, 1'b1, 3'd1);
        check("reg0_is_aa", r1dat, 8'hAA);
        cycle("wr0_55", 1'b1, 3'd0, 8'h55, 1'b0, '0, 1'b1, 3'd0, 1'b0, '0);
        cycle("wr1_aa", 1'b1, 3'd1, 8'hAA, 1'b0, '0, 1'b1, 3'd1, 1'b1, 3'd0);
        cycle("wr1_55", 1'b1, 3'd1, 8'h55, 1'b0, '0, 1'b1, 3'd1, 1'b1, 3'd0);
        cycle("wr1_aa2", 1'b1, 3'd1, 8'hAA, 1'b0, '0, 1'b1, 3'd1, 1'b1, 3'd0);

        // Flag loads.
        cycle("flag_aa", 1'b0, '0, '0, 1'b1, 8'hAA, 1'b1, 3'd0, 1'b1, 3'd1);
        check("flag_is_aa", ofdat, 8'hAA);
        cycle("flag_55", 1'b0, '0, '0, 1'b1, 8'h55, 1'b1, 3'd0, 1'b1, 3'd1);
        check("flag_is_55", ofdat, 8'h55);

        // Dual read, then drop port 2 enable.
        cycle("dual", 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd0, 1'b1, 3'd1);
        check("dual_r1", r1dat, 8'h55);
        check("dual_r2", r2dat, 8'hAA);
        cycle("r2_off", 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd0, 1'b0, 3'd1);
        check("r2_off_zero", r2dat, 8'h00);

        // Same-cycle read/write, then reset asserted mid-write.
        cycle("wr2_11", 1'b1, 3'd2, 8'h11, 1'b0, '0, 1'b1, 3'd2, 1'b1, 3'd2);
        cycle("rw2_22", 1'b1, 3'd2, 8'h22, 1'b1, 8'h0F, 1'b1, 3'd2, 1'b1, 3'd2);
        cycle("rd2_22", 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd2, 1'b1, 3'd1);
        check("reg2_is_22", r1dat, 8'h22);
        wrenb = 1'b1; waddr = 3'd2; wdata = 8'h33; flenb = 1'b1; ifdat = 8'hC3;
        r1enb = 1'b1; r1add = 3'd2; r2enb = 1'b1; r2add = 3'd0;
        #2 rst = 1'b0;
        #1;
        check("midrst_r1", r1dat, 8'h00);
        check("midrst_r2", r2dat, 8'h00);
        check("midrst_of", ofdat, 8'h00);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle("after_rst", 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd2, 1'b1, 3'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 250; i++)
            cycle("rand", 1'($urandom), addr_t'($urandom_range(0, 7)), data_t'($urandom),
                  1'($urandom_range(0, 3) == 0), data_t'($urandom),
                  1'($urandom_range(0, 4) != 0), addr_t'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0), addr_t'($urandom_range(0, 7)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
